// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared states, program base addresses and absolute branch targets.
package prog_seq_pkg;
  localparam int PC_W = 12;
  localparam int OFF_W = 6;
  localparam int LUT_W = 4;
  localparam int CNT_WD = 16;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  localparam logic [11:0] PROG_BASE [4] = '{12'h000, 12'h100, 12'h200, 12'h300};
  localparam logic [11:0] BR_LUT [16] = '{
    12'h010, 12'h020, 12'h055, 12'h0A4, 12'h123, 12'h1F0, 12'h234, 12'h2AA,
    12'h300, 12'h3C3, 12'h456, 12'h5A5, 12'h789, 12'h800, 12'hABC, 12'hFFF
  };
endpackage

// File: rtl/branch_target_lut.sv
// branch_target_lut: combinational ROM mapping a branch index to its absolute target.
module branch_target_lut import prog_seq_pkg::*; #(
  parameter int PC_WIDTH = PC_W,
  parameter int LUT_AW = LUT_W
) (
  input  logic [LUT_AW-1:0]   idx,
  output logic [PC_WIDTH-1:0] tgt
);
  assign tgt = PC_WIDTH'(BR_LUT[4'(idx)]);
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: program start/done handshake, branch resolution and RUN-cycle counting
// in front of the PC register.
module prog_sequencer import prog_seq_pkg::*; #(
  parameter int PC_WIDTH = PC_W,
  parameter int OFF_WIDTH = OFF_W,
  parameter int LUT_AW = LUT_W,
  parameter int CNT_W = CNT_WD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           prog_sel,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 halt,
  input  logic                 br_req,
  input  logic                 br_rel,
  input  logic [OFF_WIDTH-1:0] br_off,
  input  logic [LUT_AW-1:0]    br_idx,
  input  logic                 alu_flag,
  output logic                 branch_en,
  output logic [PC_WIDTH-1:0]  target,
  output logic                 exec_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_cnt
);
  state_t state_q, state_d;
  logic [1:0] prog_q, prog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] lut_tgt, rel_tgt;
  logic run, launch, take;
  branch_target_lut #(.PC_WIDTH(PC_WIDTH), .LUT_AW(LUT_AW)) u_lut (
    .idx(br_idx),
    .tgt(lut_tgt)
  );
  always_comb begin
    state_d = state_q;
    prog_d = prog_q;
    cnt_d = cnt_q;
    if (start) begin
      state_d = LAUNCH;
      prog_d = prog_sel;
      cnt_d = '0;
    end else if (state_q == LAUNCH) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      state_d = halt ? DONE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prog_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      prog_q <= prog_d;
      cnt_q <= cnt_d;
    end
  end
  assign run = state_q == RUN;
  assign launch = state_q == LAUNCH;
  // halt suppresses a same-cycle branch so the final PC load never happens
  assign take = run & br_req & alu_flag & ~halt;
  assign rel_tgt = pc + {{(PC_WIDTH-OFF_WIDTH){br_off[OFF_WIDTH-1]}}, br_off};
  assign branch_en = launch | take;
  assign target = launch ? PC_WIDTH'(PROG_BASE[prog_q]) : take ? (br_rel ? rel_tgt : lut_tgt) : '0;
  assign exec_en = run;
  assign busy = launch | run;
  assign done = state_q == DONE;
  assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench; a spec-level model predicts each cycle's outputs,
// a negedge monitor pops and compares against the default DUT and a CNT_W=4 copy.
module tb_prog_sequencer;
  logic clk = 0;
  logic reset, start, halt, br_req, br_rel, alu_flag;
  logic [1:0] prog_sel;
  logic [11:0] pc;
  logic [5:0] br_off;
  logic [3:0] br_idx;
  logic branch_en, exec_en, busy, done, branch_en4, exec_en4, busy4, done4;
  logic [11:0] target, target4;
  logic [15:0] cycle_cnt;
  logic [3:0] cycle_cnt4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  prog_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .pc(pc), .halt(halt),
    .br_req(br_req), .br_rel(br_rel), .br_off(br_off), .br_idx(br_idx), .alu_flag(alu_flag),
    .branch_en(branch_en), .target(target), .exec_en(exec_en), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );
  prog_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .pc(pc), .halt(halt),
    .br_req(br_req), .br_rel(br_rel), .br_off(br_off), .br_idx(br_idx), .alu_flag(alu_flag),
    .branch_en(branch_en4), .target(target4), .exec_en(exec_en4), .busy(busy4), .done(done4),
    .cycle_cnt(cycle_cnt4)
  );
  typedef struct {
    string tag;
    logic be;
    logic [11:0] tg;
    logic ex, bz, dn;
    logic [15:0] cnt;
    logic [3:0] cnt4;
  } exp_t;
  exp_t sb[$];
  logic [11:0] lut [16] = '{12'h010, 12'h020, 12'h055, 12'h0A4, 12'h123, 12'h1F0, 12'h234, 12'h2AA,
                            12'h300, 12'h3C3, 12'h456, 12'h5A5, 12'h789, 12'h800, 12'hABC, 12'hFFF};
  // model: phase 0 idle, 1 launching, 2 running, 3 finished; runs = RUN cycles since start
  int phase, prog, runs;
  bit valid = 0;
  string tag = "init";
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".branch_en"}, 32'(branch_en), 32'(e.be));
      chk({e.tag, ".target"}, 32'(target), 32'(e.tg));
      chk({e.tag, ".exec_en"}, 32'(exec_en), 32'(e.ex));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.bz));
      chk({e.tag, ".done"}, 32'(done), 32'(e.dn));
      chk({e.tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(e.cnt));
      chk({e.tag, ".cycle_cnt4"}, 32'(cycle_cnt4), 32'(e.cnt4));
      chk({e.tag, ".done4"}, 32'(done4), 32'(e.dn));
    end
  end
  task automatic clr();
    start = 0; prog_sel = 0; halt = 0; br_req = 0; br_rel = 0; br_off = 0; br_idx = 0;
    alu_flag = 0; pc = 12'(($urandom));
  endtask
  task automatic tick();
    exp_t e;
    int off;
    if (valid) begin
      off = $signed(br_off);
      e.tag = tag;
      e.be = 0; e.tg = 0; e.ex = 0; e.bz = 0; e.dn = 0;
      e.cnt = runs > 65535 ? 16'hFFFF : 16'(runs);
      e.cnt4 = runs > 15 ? 4'hF : 4'(runs);
      if (phase == 1) begin
        e.be = 1; e.tg = 12'(prog * 'h100); e.bz = 1;
      end else if (phase == 2) begin
        e.ex = 1; e.bz = 1;
        if (br_req && alu_flag && !halt) begin
          e.be = 1;
          e.tg = br_rel ? 12'((int'(pc) + off) & 'hFFF) : lut[br_idx];
        end
      end else if (phase == 3) e.dn = 1;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!reset) begin phase = 0; prog = 0; runs = 0; valid = 1; end
    else if (valid) begin
      if (start) begin phase = 1; prog = prog_sel; runs = 0; end
      else if (phase == 1) phase = 2;
      else if (phase == 2) begin runs++; if (halt) phase = 3; end
    end
    #1;
  endtask
  initial begin
    reset = 0; clr(); start = 1; prog_sel = 3;
    @(posedge clk); #1;
    tag = "rst"; tick(); tick();
    reset = 1; clr(); tag = "idle"; tick(); tick();
    start = 1; prog_sel = 2; tag = "start2"; tick();
    clr(); tag = "launch2"; tick();
    tag = "run2"; repeat (4) tick();
    pc = 12'h205; br_req = 1; br_rel = 1; br_off = 6'b111010; alu_flag = 1; tag = "rel_neg"; tick();
    alu_flag = 0; tag = "rel_nottaken"; tick();
    pc = 12'hFFE; br_off = 6'd3; alu_flag = 1; tag = "rel_wrap"; tick();
    br_rel = 0; br_idx = 3; tag = "abs3"; tick();
    br_idx = 15; tag = "abs15"; tick();
    halt = 1; tag = "halt_br"; tick();
    clr(); br_req = 1; alu_flag = 1; tag = "done"; tick(); tick();
    start = 1; prog_sel = 1; tag = "restart1"; tick();
    clr(); tag = "launch1"; tick();
    tag = "run1"; repeat (3) tick();
    start = 1; halt = 1; prog_sel = 0; tag = "start_halt"; tick();
    clr(); tag = "relaunch0"; tick();
    tag = "sat"; repeat (20) tick();
    reset = 0; tag = "rst_mid"; tick();
    reset = 1; tag = "post_rst"; tick(); tick();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) != 0);
      start = ($urandom_range(15) == 0);
      halt = ($urandom_range(15) == 0);
      prog_sel = 2'($urandom); pc = 12'($urandom); br_req = 1'($urandom);
      br_rel = 1'($urandom); br_off = 6'($urandom); br_idx = 4'($urandom);
      alu_flag = 1'($urandom);
      tag = "rand"; tick();
    end
    clr(); tag = "tail"; tick();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
